// File: rtl/btn_gesture_if.sv
// Button gesture link between the edge detector side (master) and the gesture classifier (slave).
// The press/rel inputs and the event pulses carry no valid/ready: every signal is a one-cycle pulse, and a 1 means the event happened on that clock.
interface btn_gesture_if;
  logic press;
  logic rel;
  logic single;
  logic dbl;
  logic long_pr;
  logic rpt;
  logic busy;

  modport master (
    output press, rel,
    input  single, dbl, long_pr, rpt, busy
  );

  modport slave (
    input  press, rel,
    output single, dbl, long_pr, rpt, busy
  );
endinterface

// File: rtl/btn_gesture.sv
// Classifies press/release pulses into single, double, long-press and auto-repeat events.
// Every output is registered. At most one event pulse is high on any cycle.
module btn_gesture #(
    parameter int CLK_HZ    = 27_000_000,
    parameter int LONG_MS   = 500,
    parameter int DBL_MS    = 250,
    parameter int REPEAT_MS = 100
) (
    input  logic               clk,
    input  logic               rst,
    btn_gesture_if.slave       bus,
    output logic [2:0]         dbg_state
);
    localparam int LONG_CYC = CLK_HZ / 1000 * LONG_MS;
    localparam int DBL_CYC  = CLK_HZ / 1000 * DBL_MS;
    localparam int REP_CYC  = CLK_HZ / 1000 * REPEAT_MS;
    localparam int MAX_CYC  = (LONG_CYC > DBL_CYC)
                              ? ((LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC)
                              : ((DBL_CYC > REP_CYC) ? DBL_CYC : REP_CYC);
    localparam int TW = $clog2(MAX_CYC) + 1;

    localparam logic [TW-1:0] LONG_T = TW'(LONG_CYC);
    localparam logic [TW-1:0] DBL_T  = TW'(DBL_CYC);
    localparam logic [TW-1:0] REP_T  = TW'(REP_CYC);
    localparam logic [TW-1:0] ONE_T  = TW'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HELD1 = 3'd1,
        WAIT2 = 3'd2,
        HELD2 = 3'd3,
        LONG  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d, timer_inc;
    logic          single_d, dbl_d, long_d, rpt_d;
    logic          pr, rl;

    // A press and a release on the same cycle count as a glitch, so both are dropped.
    assign pr = bus.press & ~bus.rel;
    assign rl = bus.rel & ~bus.press;
    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + ONE_T;

    // The timer holds 1 on the first cycle in a timed state, so a decision
    // falls on the cycle where the timer equals the configured length.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_inc;
        single_d = 1'b0;
        dbl_d    = 1'b0;
        long_d   = 1'b0;
        rpt_d    = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (pr) begin
                    state_d = HELD1;
                    timer_d = ONE_T;
                end
            end
            HELD1: begin
                if (rl) begin
                    state_d = WAIT2;
                    timer_d = ONE_T;
                end else if (timer_q >= LONG_T) begin
                    long_d  = 1'b1;
                    state_d = LONG;
                    timer_d = ONE_T;
                end
            end
            WAIT2: begin
                if (pr) begin
                    dbl_d   = 1'b1;
                    state_d = HELD2;
                    timer_d = '0;
                end else if (timer_q >= DBL_T) begin
                    single_d = 1'b1;
                    state_d  = IDLE;
                    timer_d  = '0;
                end
            end
            HELD2: begin
                timer_d = '0;
                if (rl) state_d = IDLE;
            end
            LONG: begin
                if (rl) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q >= REP_T) begin
                    rpt_d   = 1'b1;
                    timer_d = ONE_T;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // busy stays up through the cycle that carries the single pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            bus.single  <= 1'b0;
            bus.dbl     <= 1'b0;
            bus.long_pr <= 1'b0;
            bus.rpt     <= 1'b0;
            bus.busy    <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bus.single  <= single_d;
            bus.dbl     <= dbl_d;
            bus.long_pr <= long_d;
            bus.rpt     <= rpt_d;
            bus.busy    <= (state_d != IDLE) | single_d;
        end
    end

    assign dbg_state = state_q;
endmodule
